// File: rtl/flag_hazard_ctrl_pkg.sv
// Shared definitions for the flag hazard controller: flag bit positions,
// branch condition codes and the stall FSM encoding.
package flag_hazard_ctrl_pkg;

    // Bit positions inside the {Z,V,N} flag vectors
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_N = 0;

    // Conditional branch condition codes
    typedef enum logic [2:0] {
        COND_NE     = 3'b000,
        COND_EQ     = 3'b001,
        COND_GT     = 3'b010,
        COND_LT     = 3'b011,
        COND_GE     = 3'b100,
        COND_LE     = 3'b101,
        COND_OV     = 3'b110,
        COND_UNCOND = 3'b111
    } cond_e;

    // Flag-hazard stall FSM
    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/flag_hazard_ctrl_if.sv
// ID/EX-side signal bundle between the pipeline and the flag hazard controller.
// The pipeline is the master; the controller is the slave.
interface flag_hazard_ctrl_if;

    logic       id_valid;
    logic [2:0] id_flag_wr;
    logic       id_is_br;
    logic [2:0] id_br_cond;
    logic       id_flush;
    logic       stall_ext;

    logic [2:0] flag_we;
    logic       stall_id;
    logic       br_flags_ok;
    logic [2:0] ex_flag_mask;

    modport master (
        output id_valid, id_flag_wr, id_is_br, id_br_cond, id_flush, stall_ext,
        input  flag_we, stall_id, br_flags_ok, ex_flag_mask
    );

    modport slave (
        input  id_valid, id_flag_wr, id_is_br, id_br_cond, id_flush, stall_ext,
        output flag_we, stall_id, br_flags_ok, ex_flag_mask
    );

endinterface

// File: rtl/flag_hazard_ctrl_cond_need.sv
// Combinational decode of a branch condition code to the {Z,V,N} flags it reads.
module flag_cond_need
    import flag_hazard_ctrl_pkg::*;
(
    input  logic [2:0] cond,
    output logic [2:0] need
);

    // Map each condition code onto the flags its evaluation depends on
    always_comb begin
        need = '0;
        unique case (cond_e'(cond))
            COND_NE, COND_EQ: begin
                need[FLAG_Z] = 1'b1;
            end
            COND_GT, COND_GE, COND_LE: begin
                need[FLAG_Z] = 1'b1;
                need[FLAG_N] = 1'b1;
            end
            COND_LT: begin
                need[FLAG_N] = 1'b1;
            end
            COND_OV: begin
                need[FLAG_V] = 1'b1;
            end
            COND_UNCOND: begin
                need = '0;
            end
            default: begin
                need = '0;
            end
        endcase
    end

endmodule

// File: rtl/flag_hazard_ctrl.sv
// Flag hazard controller: tracks the flags the EX instruction will write,
// drives the flag register write enables, stalls ID branches that depend on
// a flag still in flight, and counts those stall cycles (saturating).
module flag_hazard_ctrl
    import flag_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    flag_hazard_ctrl_if.slave bus,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [2:0]       need;
    logic             br_live;
    logic             hazard;
    logic             stall_id;
    logic [2:0]       ex_mask_q;
    logic [2:0]       ex_mask_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    state_e           state_q;
    state_e           state_d;

    flag_cond_need u_cond_need (
        .cond (bus.id_br_cond),
        .need (need)
    );

    // Hazard detection and combinational stage outputs
    always_comb begin
        br_live          = bus.id_valid & bus.id_is_br & ~bus.id_flush;
        hazard           = br_live & (|(need & ex_mask_q));
        stall_id         = hazard & ~bus.stall_ext;
        bus.stall_id     = stall_id;
        bus.br_flags_ok  = br_live & ~hazard & ~bus.stall_ext;
        bus.flag_we      = ex_mask_q & {3{~bus.stall_ext}};
        bus.ex_flag_mask = ex_mask_q;
        stall_cnt        = cnt_q;
    end

    // Next EX pending-write mask: freeze holds, stall/flush/empty inject a bubble
    always_comb begin
        ex_mask_d = ex_mask_q;
        if (bus.stall_ext) begin
            ex_mask_d = ex_mask_q;
        end else if (stall_id || bus.id_flush || !bus.id_valid) begin
            ex_mask_d = '0;
        end else begin
            ex_mask_d = bus.id_flag_wr;
        end
    end

    // Next FSM state: one HOLD cycle follows each flag stall
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (stall_id) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!bus.stall_ext) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Next stall counter value: clear wins, increment saturates at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (stall_id && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_mask_q <= '0;
            cnt_q     <= '0;
            state_q   <= RUN;
        end else begin
            ex_mask_q <= ex_mask_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
        end
    end

    // The bubble inserted on a stall means HOLD can never see another hazard
    hold_no_stall : assert property (
        @(posedge clk) disable iff (!rst_n) (state_q == HOLD) |-> !stall_id
    );

endmodule

// File: tb/tb_flag_hazard_ctrl.sv
// Directed bench for flag_hazard_ctrl with a cycle-level reference model.
module tb_flag_hazard_ctrl;

    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cnt_clr;
    logic [CNT_W-1:0] stall_cnt;

    int n_total = 0;
    int n_pass  = 0;

    flag_hazard_ctrl_if bus ();

    flag_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .cnt_clr   (cnt_clr),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: flags owed by the instruction in EX, and an unbounded stall tally
    logic [2:0] m_pend;
    int         m_stalls;

    function automatic logic [2:0] need_of(input logic [2:0] c);
        case (c)
            3'd0, 3'd1:       return 3'b100;
            3'd2, 3'd4, 3'd5: return 3'b101;
            3'd3:             return 3'b001;
            3'd6:             return 3'b010;
            default:          return 3'b000;
        endcase
    endfunction

    function automatic bit exp_hazard();
        bit live;
        live = bus.id_valid && bus.id_is_br && !bus.id_flush;
        return live && ((need_of(bus.id_br_cond) & m_pend) != 3'b000);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend   = 3'b000;
            m_stalls = 0;
        end else begin
            bit stall;
            stall = exp_hazard() && !bus.stall_ext;
            if (cnt_clr) m_stalls = 0;
            else if (stall) m_stalls = m_stalls + 1;
            if (!bus.stall_ext)
                m_pend = (bus.id_valid && !bus.id_flush && !stall) ? bus.id_flag_wr : 3'b000;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_check();
        bit haz;
        bit live;
        live = bus.id_valid && bus.id_is_br && !bus.id_flush;
        haz  = exp_hazard();
        chk("m_stall_id",  int'(bus.stall_id),     int'(haz && !bus.stall_ext));
        chk("m_br_ok",     int'(bus.br_flags_ok),  int'(live && !haz && !bus.stall_ext));
        chk("m_flag_we",   int'(bus.flag_we),      bus.stall_ext ? 0 : int'(m_pend));
        chk("m_ex_mask",   int'(bus.ex_flag_mask), int'(m_pend));
        chk("m_stall_cnt", int'(stall_cnt),        (m_stalls > CNT_MAX) ? CNT_MAX : m_stalls);
    endtask

    // One pipeline cycle: drive after the edge, compare at the falling edge
    task automatic cyc(input logic v, input logic [2:0] wr, input logic br,
                       input logic [2:0] cond, input logic fl, input logic se,
                       input logic clr);
        @(posedge clk);
        #1;
        bus.id_valid   = v;
        bus.id_flag_wr = wr;
        bus.id_is_br   = br;
        bus.id_br_cond = cond;
        bus.id_flush   = fl;
        bus.stall_ext  = se;
        cnt_clr        = clr;
        @(negedge clk);
        model_check();
    endtask

    task automatic nop(input logic clr = 1'b0);
        cyc(1'b0, 3'b000, 1'b0, 3'd0, 1'b0, 1'b0, clr);
    endtask

    task automatic alu(input logic [2:0] wr);
        cyc(1'b1, wr, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic br(input logic [2:0] cond, input logic fl = 1'b0,
                      input logic se = 1'b0, input logic clr = 1'b0);
        cyc(1'b1, 3'b000, 1'b1, cond, fl, se, clr);
    endtask

    initial begin
        rst_n          = 1'b0;
        cnt_clr        = 1'b0;
        bus.id_valid   = 1'b0;
        bus.id_flag_wr = 3'b000;
        bus.id_is_br   = 1'b0;
        bus.id_br_cond = 3'd0;
        bus.id_flush   = 1'b0;
        bus.stall_ext  = 1'b0;

        // Reset values, and a branch present during reset may evaluate
        #12;
        chk("rst_mask",  int'(bus.ex_flag_mask), 0);
        chk("rst_cnt",   int'(stall_cnt), 0);
        chk("rst_we",    int'(bus.flag_we), 0);
        chk("rst_stall", int'(bus.stall_id), 0);
        chk("rst_brok0", int'(bus.br_flags_ok), 0);
        bus.id_valid   = 1'b1;
        bus.id_is_br   = 1'b1;
        bus.id_br_cond = 3'd1;
        #1;
        chk("rst_brok1", int'(bus.br_flags_ok), 1);
        bus.id_valid   = 1'b0;
        bus.id_is_br   = 1'b0;
        bus.id_br_cond = 3'd0;
        #1;
        rst_n = 1'b1;

        // ADD then B EQ: one stall cycle, flags written during it
        alu(3'b111);
        br(3'd1);
        chk("t1_stall", int'(bus.stall_id), 1);
        chk("t1_we",    int'(bus.flag_we), 7);
        br(3'd1);
        chk("t1_stall2", int'(bus.stall_id), 0);
        chk("t1_brok",   int'(bus.br_flags_ok), 1);
        chk("t1_cnt",    int'(stall_cnt), 1);

        // XOR (Z only) then B OV: disjoint flags, no stall
        nop(1'b1);
        alu(3'b100);
        br(3'd6);
        chk("t2_stall", int'(bus.stall_id), 0);
        chk("t2_brok",  int'(bus.br_flags_ok), 1);
        chk("t2_we",    int'(bus.flag_we), 4);
        nop();
        chk("t2_cnt",   int'(stall_cnt), 0);

        // ADD, NOP, B LT: flag already stored
        alu(3'b111);
        nop();
        chk("t3_we", int'(bus.flag_we), 7);
        br(3'd3);
        chk("t3_stall", int'(bus.stall_id), 0);
        chk("t3_brok",  int'(bus.br_flags_ok), 1);

        // ADD then B GT under a 3-cycle freeze
        nop(1'b1);
        alu(3'b111);
        for (int i = 0; i < 3; i++) begin
            br(3'd2, 1'b0, 1'b1);
            chk("t4_frz_stall", int'(bus.stall_id), 0);
            chk("t4_frz_we",    int'(bus.flag_we), 0);
            chk("t4_frz_mask",  int'(bus.ex_flag_mask), 7);
        end
        br(3'd2);
        chk("t4_stall", int'(bus.stall_id), 1);
        br(3'd2);
        chk("t4_brok", int'(bus.br_flags_ok), 1);
        nop();
        chk("t4_cnt", int'(stall_cnt), 1);

        // ADD then flushed B EQ: no stall, bubble into EX
        alu(3'b111);
        br(3'd1, 1'b1);
        chk("t5_stall", int'(bus.stall_id), 0);
        chk("t5_brok",  int'(bus.br_flags_ok), 0);
        nop();
        chk("t5_mask", int'(bus.ex_flag_mask), 0);

        // Non-branch and unconditional branch after a writer never stall
        alu(3'b111);
        alu(3'b011);
        chk("t6_alu_stall", int'(bus.stall_id), 0);
        br(3'd7);
        chk("t6_unc_stall", int'(bus.stall_id), 0);
        chk("t6_unc_brok",  int'(bus.br_flags_ok), 1);

        // Saturation after 20 stalls, then clear racing an increment
        nop(1'b1);
        for (int i = 0; i < 20; i++) begin
            alu(3'b111);
            br(3'd1);
            br(3'd1);
        end
        nop();
        chk("t7_sat", int'(stall_cnt), 15);
        alu(3'b111);
        br(3'd1, 1'b0, 1'b0, 1'b1);
        chk("t7_clr_stall", int'(bus.stall_id), 1);
        nop();
        chk("t7_clr", int'(stall_cnt), 0);

        // Asynchronous reset with a pending mask, and again during HOLD
        alu(3'b111);
        nop();
        chk("t8_pre_mask", int'(bus.ex_flag_mask), 7);
        #1 rst_n = 1'b0;
        #1;
        chk("t8_mask", int'(bus.ex_flag_mask), 0);
        chk("t8_we",   int'(bus.flag_we), 0);
        #1 rst_n = 1'b1;
        alu(3'b111);
        br(3'd5);
        chk("t8_stall", int'(bus.stall_id), 1);
        br(3'd5);
        #1 rst_n = 1'b0;
        #1;
        chk("t8_hold_mask", int'(bus.ex_flag_mask), 0);
        chk("t8_hold_cnt",  int'(stall_cnt), 0);
        #1 rst_n = 1'b1;
        alu(3'b001);
        br(3'd3);
        chk("t8_post_stall", int'(bus.stall_id), 1);
        br(3'd3);
        chk("t8_post_brok", int'(bus.br_flags_ok), 1);
        nop();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
